// File: rtl/i2c_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile_if
// Pad-side I2C signals of the register-file slave.
//   SCL        : I2C clock as seen on the wire
//   SDA        : I2C data as seen on the wire (already wired-AND with the pull)
//   sda_intern : 1 = slave pulls SDA low (open-drain enable)
// Modports: slave (the register file), master (bus model / pad side).
// -----------------------------------------------------------------------------
interface i2c_slave_regfile_if;
    logic SCL;
    logic SDA;
    logic sda_intern;

    modport slave  (input SCL, input SDA, output sda_intern);
    modport master (output SCL, output SDA, input sda_intern);
endinterface

// File: rtl/i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile
// I2C slave answering ADDRESSNUM addresses, each owning a bank of NBYTES bytes
// reached through a shared auto-incrementing register pointer. SCL/SDA are
// oversampled on CLK.
// Ports:
//   CLK, RST     : system clock, synchronous active-high reset
//   bus          : SCL/SDA in, sda_intern out (1 = pull SDA low)
//   AddressList  : static list of answered addresses, entry k at [k*AL +: AL]
//   WrEn/WrBank/WrPtr/WrData : one-cycle strobe per master-written byte
//   RdBank/RdPtr/RdData      : combinational local read port
//   Busy         : high from an addressed START until STOP
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
    parameter int ADDRESSLENGTH = 7,
    parameter int ADDRESSNUM    = 2,
    parameter int NBYTES        = 4,
    localparam int PW = $clog2(NBYTES),
    localparam int IW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    i2c_slave_regfile_if.slave                  bus,
    input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
    output logic                                WrEn,
    output logic [IW-1:0]                       WrBank,
    output logic [PW-1:0]                       WrPtr,
    output logic [7:0]                          WrData,
    input  logic [IW-1:0]                       RdBank,
    input  logic [PW-1:0]                       RdPtr,
    output logic [7:0]                          RdData,
    output logic                                Busy
);

    // Shift register holds either address+R/W or a data byte.
    localparam int SW = (ADDRESSLENGTH + 1 > 8) ? ADDRESSLENGTH + 1 : 8;
    localparam int CW = $clog2(SW + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    // Lowest matching index wins: scan downwards so the last hit is the lowest.
    function automatic logic [IW:0] addr_lookup(
        input logic [ADDRESSLENGTH-1:0]            a,
        input logic [ADDRESSLENGTH*ADDRESSNUM-1:0] list
    );
        logic [IW:0] r;
        r = '0;
        for (int k = ADDRESSNUM - 1; k >= 0; k--) begin
            if (list[k*ADDRESSLENGTH +: ADDRESSLENGTH] == a) begin
                r = {1'b1, IW'(k)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Pointer advance with explicit wrap (NBYTES need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NBYTES - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    state_t        state_q,   state_d;
    logic [CW-1:0] bitcnt_q,  bitcnt_d;
    logic [SW-1:0] shreg_q,   shreg_d;
    logic          rw_q,      rw_d;
    logic [IW-1:0] bank_q,    bank_d;
    logic [PW-1:0] ptr_q,     ptr_d;
    logic          sda_q,     sda_d;
    logic          busy_q,    busy_d;
    logic          wr_en_q,   wr_en_d;
    logic [IW-1:0] wr_bank_q, wr_bank_d;
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    mem_q [ADDRESSNUM][NBYTES];

    logic          scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [SW-1:0] shift_nxt_s;
    logic [IW:0]   lookup_s;
    logic [7:0]    rd_byte_s;

    // Synchroniser plus edge-detect stage; deliberately not reset so that a
    // mid-transfer RST cannot fabricate a START/STOP from stale history.
    always_ff @(posedge CLK) begin
        scl_meta_q <= bus.SCL;
        scl_sync_q <= scl_meta_q;
        scl_prev_q <= scl_sync_q;
        sda_meta_q <= bus.SDA;
        sda_sync_q <= sda_meta_q;
        sda_prev_q <= sda_sync_q;
    end

    // Bus events decoded from the synchronised samples.
    always_comb begin
        scl_rise_s  = scl_sync_q & ~scl_prev_q;
        scl_fall_s  = ~scl_sync_q & scl_prev_q;
        start_s     = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
        stop_s      = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
        shift_nxt_s = {shreg_q[SW-2:0], sda_sync_q};
        lookup_s    = addr_lookup(shift_nxt_s[ADDRESSLENGTH:1], AddressList);
        rd_byte_s   = mem_q[bank_q][ptr_q];
    end

    // Protocol FSM next-state and datapath.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        rw_d      = rw_q;
        bank_d    = bank_q;
        ptr_d     = ptr_q;
        sda_d     = sda_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        wr_data_d = wr_data_q;

        if (stop_s) begin
            state_d  = S_IDLE;
            bitcnt_d = CW'(0);
            sda_d    = 1'b0;
            busy_d   = 1'b0;
        end else if (start_s) begin
            // ptr survives a repeated START so pointer-write/read sequences work.
            state_d  = S_ADDR;
            bitcnt_d = CW'(0);
            sda_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_WAIT: begin
                    sda_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise_s) begin
                        shreg_d = shift_nxt_s;
                        if (bitcnt_q == CW'(ADDRESSLENGTH)) begin
                            bitcnt_d = CW'(0);
                            if (lookup_s[IW]) begin
                                state_d = S_ADDR_ACK;
                                bank_d  = lookup_s[IW-1:0];
                                rw_d    = shift_nxt_s[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + CW'(1);
                        end
                    end else begin
                        shreg_d = shreg_q;
                    end
                end
                // ACK phases: first falling edge pulls, second releases.
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (bitcnt_q == CW'(0)) begin
                            sda_d    = 1'b1;
                            bitcnt_d = CW'(1);
                        end else begin
                            sda_d    = 1'b0;
                            bitcnt_d = CW'(0);
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                // Same edge that ends the ACK drives the first read bit.
                                state_d  = S_RDATA;
                                sda_d    = ~rd_byte_s[7];
                                shreg_d  = SW'({rd_byte_s[6:0], 1'b0});
                                bitcnt_d = CW'(1);
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end else begin
                        sda_d = sda_q;
                    end
                end
                S_PTR: begin
                    if (scl_rise_s) begin
                        shreg_d = shift_nxt_s;
                        if (bitcnt_q == CW'(7)) begin
                            bitcnt_d = CW'(0);
                            if ({24'd0, shift_nxt_s[7:0]} < 32'(NBYTES)) begin
                                ptr_d   = PW'(shift_nxt_s[7:0]);
                                state_d = S_PTR_ACK;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + CW'(1);
                        end
                    end else begin
                        shreg_d = shreg_q;
                    end
                end
                S_WDATA: begin
                    if (scl_rise_s) begin
                        shreg_d = shift_nxt_s;
                        if (bitcnt_q == CW'(7)) begin
                            bitcnt_d  = CW'(0);
                            wr_en_d   = 1'b1;
                            wr_bank_d = bank_q;
                            wr_ptr_d  = ptr_q;
                            wr_data_d = shift_nxt_s[7:0];
                            ptr_d     = ptr_inc(ptr_q);
                            state_d   = S_WDATA_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q + CW'(1);
                        end
                    end else begin
                        shreg_d = shreg_q;
                    end
                end
                // bitcnt counts bits already driven; 8 means the byte is out.
                S_RDATA: begin
                    if (scl_fall_s) begin
                        if (bitcnt_q == CW'(0)) begin
                            sda_d    = ~rd_byte_s[7];
                            shreg_d  = SW'({rd_byte_s[6:0], 1'b0});
                            bitcnt_d = CW'(1);
                        end else if (bitcnt_q < CW'(8)) begin
                            sda_d    = ~shreg_q[7];
                            shreg_d  = shreg_q << 1;
                            bitcnt_d = bitcnt_q + CW'(1);
                        end else begin
                            sda_d    = 1'b0;
                            bitcnt_d = CW'(0);
                            ptr_d    = ptr_inc(ptr_q);
                            state_d  = S_RDATA_ACK;
                        end
                    end else begin
                        sda_d = sda_q;
                    end
                end
                S_RDATA_ACK: begin
                    sda_d = 1'b0;
                    if (scl_rise_s) begin
                        bitcnt_d = CW'(0);
                        if (sda_sync_q == 1'b0) begin
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_RDATA_ACK;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    bitcnt_d = CW'(0);
                    sda_d    = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // State, output and register-file update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= CW'(0);
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            bank_q    <= '0;
            ptr_q     <= '0;
            sda_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= '0;
            wr_ptr_q  <= '0;
            wr_data_q <= 8'h00;
            for (int b = 0; b < ADDRESSNUM; b++) begin
                for (int i = 0; i < NBYTES; i++) begin
                    mem_q[b][i] <= 8'h00;
                end
            end
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            bank_q    <= bank_d;
            ptr_q     <= ptr_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_data_q <= wr_data_d;
            if (wr_en_d) begin
                mem_q[wr_bank_d][wr_ptr_d] <= wr_data_d;
            end
        end
    end

    assign bus.sda_intern = sda_q;
    assign WrEn           = wr_en_q;
    assign WrBank         = wr_bank_q;
    assign WrPtr          = wr_ptr_q;
    assign WrData         = wr_data_q;
    assign Busy           = busy_q;
    assign RdData         = mem_q[RdBank][RdPtr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_regfile
// Directed bit-banged I2C master against i2c_slave_regfile with
// AddressList = {0x3C (bank 1), 0x50 (bank 0)}, NBYTES = 4.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [1:0]  wr_ptr;
    logic [7:0]  wr_data;
    logic [0:0]  rd_bank;
    logic [1:0]  rd_ptr;
    logic [7:0]  rd_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_slave_regfile_if bus ();
    assign bus.SCL = scl_m;
    assign bus.SDA = sda_m & ~bus.sda_intern;

    i2c_slave_regfile #(
        .ADDRESSLENGTH(7),
        .ADDRESSNUM   (2),
        .NBYTES       (4)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .bus        (bus),
        .AddressList({7'h3C, 7'h50}),
        .WrEn       (wr_en),
        .WrBank     (wr_bank),
        .WrPtr      (wr_ptr),
        .WrData     (wr_data),
        .RdBank     (rd_bank),
        .RdPtr      (rd_ptr),
        .RdData     (rd_data),
        .Busy       (busy)
    );

    // Write-strobe log and activity counters, sampled mid-cycle.
    logic [10:0] wr_log [0:63];
    int wr_n     = 0;
    int sda_cnt  = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_log[wr_n[5:0]] = {wr_bank, wr_ptr, wr_data};
            wr_n = wr_n + 1;
        end
        if (bus.sda_intern) sda_cnt = sda_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works both from idle and as a repeated START (SCL low).
    task automatic i2c_start();
        sda_m = 1'b1; tick(4);
        scl_m = 1'b1; tick(8);
        sda_m = 1'b0; tick(8);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(4);
        scl_m = 1'b1; tick(8);
        sda_m = 1'b1; tick(8);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(4);
        scl_m = 1'b1; tick(8);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(4);
        scl_m = 1'b1; tick(4);
        b = bus.SDA;  tick(4);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic peek(input logic [0:0] bank, input logic [1:0] p, input string tag, input logic [7:0] exp);
        rd_bank = bank;
        rd_ptr  = p;
        tick(1);
        check_val(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        int         base_wr;
        int         base_sda;
        int         base_busy;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        rd_bank = 1'b0; rd_ptr = 2'd0;
        tick(8);
        check_val("rst_sda",    {31'd0, bus.sda_intern}, 32'd0);
        check_val("rst_wren",   {31'd0, wr_en},          32'd0);
        check_val("rst_busy",   {31'd0, busy},           32'd0);
        check_val("rst_wrdata", {24'd0, wr_data},        32'd0);
        rst = 1'b0;
        tick(4);
        peek(1'b1, 2'd3, "rst_mem13", 8'h00);

        // Write bank1 ptr1: A5 5A 11
        base_wr = wr_n;
        i2c_start();
        put_byte(8'h78, ack); check_val("t1_ack_addr", {31'd0, ack}, 32'd1);
        put_byte(8'h01, ack); check_val("t1_ack_ptr",  {31'd0, ack}, 32'd1);
        put_byte(8'hA5, ack); check_val("t1_ack_d0",   {31'd0, ack}, 32'd1);
        put_byte(8'h5A, ack); check_val("t1_ack_d1",   {31'd0, ack}, 32'd1);
        put_byte(8'h11, ack); check_val("t1_ack_d2",   {31'd0, ack}, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        check_val("t1_busy_stop", {31'd0, busy}, 32'd0);
        check_val("t1_wr_count", wr_n - base_wr, 32'd3);
        check_val("t1_wr0", {21'd0, wr_log[base_wr[5:0]]},        32'h5A5);
        check_val("t1_wr1", {21'd0, wr_log[base_wr[5:0] + 6'd1]}, 32'h65A);
        check_val("t1_wr2", {21'd0, wr_log[base_wr[5:0] + 6'd2]}, 32'h711);
        peek(1'b1, 2'd3, "t1_rd13", 8'h11);
        peek(1'b1, 2'd1, "t1_rd11", 8'hA5);

        // Pointer 3, repeated START, read 3 bytes with wrap
        base_wr = wr_n;
        i2c_start();
        put_byte(8'h78, ack); check_val("t2_ack_addr", {31'd0, ack}, 32'd1);
        put_byte(8'h03, ack); check_val("t2_ack_ptr",  {31'd0, ack}, 32'd1);
        i2c_start();
        put_byte(8'h79, ack); check_val("t2_ack_raddr", {31'd0, ack}, 32'd1);
        get_byte(d, 1'b0); check_val("t2_rd0", {24'd0, d}, 32'h11);
        get_byte(d, 1'b0); check_val("t2_rd1", {24'd0, d}, 32'h00);
        get_byte(d, 1'b1); check_val("t2_rd2", {24'd0, d}, 32'hA5);
        tick(4);
        check_val("t2_released", {31'd0, bus.sda_intern}, 32'd0);
        i2c_stop();
        check_val("t2_no_wr", wr_n - base_wr, 32'd0);

        // Unknown address 0x51
        base_wr = wr_n; base_sda = sda_cnt; base_busy = busy_cnt;
        i2c_start();
        put_byte(8'hA2, ack); check_val("t3_nack_addr", {31'd0, ack}, 32'd0);
        put_byte(8'h55, ack); check_val("t3_nack_data", {31'd0, ack}, 32'd0);
        i2c_stop();
        check_val("t3_sda_quiet", sda_cnt - base_sda,   32'd0);
        check_val("t3_busy_low",  busy_cnt - base_busy, 32'd0);
        check_val("t3_no_wr",     wr_n - base_wr,       32'd0);

        // Fill bank0 from ptr 2: 77 88 C4 D5 (ptr wraps back to 2)
        base_wr = wr_n;
        i2c_start();
        put_byte(8'hA0, ack); check_val("t4_ack_addr", {31'd0, ack}, 32'd1);
        put_byte(8'h02, ack);
        put_byte(8'h77, ack);
        put_byte(8'h88, ack);
        put_byte(8'hC4, ack);
        put_byte(8'hD5, ack); check_val("t4_ack_last", {31'd0, ack}, 32'd1);
        i2c_stop();
        check_val("t4_wr_count", wr_n - base_wr, 32'd4);
        check_val("t4_wr_last", {21'd0, wr_log[base_wr[5:0] + 6'd3]}, 32'h1D5);

        // Out-of-range pointer 7: NACK, data ignored, ptr stays 2
        base_wr = wr_n;
        i2c_start();
        put_byte(8'hA0, ack); check_val("t4_ack_addr2", {31'd0, ack}, 32'd1);
        put_byte(8'h07, ack); check_val("t4_nack_ptr",  {31'd0, ack}, 32'd0);
        put_byte(8'h99, ack); check_val("t4_nack_data", {31'd0, ack}, 32'd0);
        i2c_stop();
        check_val("t4_no_wr", wr_n - base_wr, 32'd0);
        i2c_start();
        put_byte(8'hA1, ack); check_val("t4_ack_raddr", {31'd0, ack}, 32'd1);
        get_byte(d, 1'b1); check_val("t4_ptr_kept", {24'd0, d}, 32'h77);
        i2c_stop();

        // Reset during 4th bit of reading 0x88 (bank0 ptr3)
        i2c_start();
        put_byte(8'hA1, ack); check_val("t5_ack_raddr", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 3; i++) get_bit(b);
        sda_m = 1'b1;
        tick(6);
        check_val("t5_driving", {31'd0, bus.sda_intern}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_val("t5_sda_rel", {31'd0, bus.sda_intern}, 32'd0);
        check_val("t5_busy",    {31'd0, busy},           32'd0);
        check_val("t5_wrdata",  {24'd0, wr_data},        32'd0);
        check_val("t5_wrptr",   {30'd0, wr_ptr},         32'd0);
        rst = 1'b0;
        peek(1'b0, 2'd3, "t5_mem_clr", 8'h00);
        base_sda = sda_cnt;
        scl_m = 1'b1; tick(8);
        scl_m = 1'b0; tick(4);
        for (int i = 0; i < 4; i++) get_bit(b);
        put_bit(1'b1);
        i2c_stop();
        check_val("t5_ignored", sda_cnt - base_sda, 32'd0);
        base_wr = wr_n;
        i2c_start();
        put_byte(8'h78, ack); check_val("t5_ack_addr", {31'd0, ack}, 32'd1);
        put_byte(8'h02, ack); check_val("t5_ack_ptr",  {31'd0, ack}, 32'd1);
        put_byte(8'h3E, ack); check_val("t5_ack_data", {31'd0, ack}, 32'd1);
        i2c_stop();
        check_val("t5_wr_count", wr_n - base_wr, 32'd1);
        check_val("t5_wr", {21'd0, wr_log[base_wr[5:0]]}, 32'h63E);
        peek(1'b1, 2'd2, "t5_rd12", 8'h3E);

        // STOP in the middle of a data byte
        base_wr = wr_n;
        i2c_start();
        put_byte(8'h78, ack); check_val("t6_ack_addr", {31'd0, ack}, 32'd1);
        put_byte(8'h00, ack); check_val("t6_ack_ptr",  {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        check_val("t6_busy_mid", {31'd0, busy}, 32'd1);
        i2c_stop();
        check_val("t6_no_wr", wr_n - base_wr, 32'd0);
        check_val("t6_busy",  {31'd0, busy}, 32'd0);
        peek(1'b1, 2'd0, "t6_mem10", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
